// File: rtl/serdes_pkg.sv
// Shared definitions for the serial link (serializer and deserializer).
//   - Default word width, bit-count code width and shortest legal burst.
//   - Collector state enum.
//   - Mod code meaning "full DATA_W-bit word".
// No ports.
package serdes_pkg;

    localparam int unsigned SERDES_DATA_W  = 16;
    localparam int unsigned SERDES_MOD_W   = $clog2(SERDES_DATA_W);
    localparam int unsigned SERDES_MIN_LEN = 3;

    // A full word is signalled by mod code 0, not DATA_W.
    localparam int unsigned MOD_FULL = 0;

    typedef enum logic [0:0] {
        IDLE,
        COLLECT
    } serdes_state_e;

endpackage

// File: rtl/deserializer.sv
// Serial-to-parallel receiver for MSB-first bursts qualified by a valid strobe.
// Each burst is packed left-justified into a DATA_W-bit word. A one-cycle
// pulse is produced when the word fills, or when the burst ends with at least
// MIN_LEN bits. Shorter bursts (runts) are dropped.
//
// Ports:
//   clk_i             clock, all logic on posedge
//   srst_i            synchronous reset, active-high, highest priority
//   ser_data_i        serial bit, sampled when ser_data_val_i=1
//   ser_data_val_i    bit strobe; contiguous high cycles form one burst
//   deser_data_o      assembled word, MSB = first received bit (held between pulses)
//   deser_data_mod_o  valid-bit count, 0 = full word (held between pulses)
//   deser_data_val_o  one-cycle pulse qualifying data/mod
//   runt_cnt_o        saturating count of dropped runts (only with DESERIALIZER_RUNT_CNT_EN)
//   busy_o            a partially collected word is held
//
// Build option: define DESERIALIZER_RUNT_CNT_EN to add the runt counter and runt_cnt_o.
module deserializer
    import serdes_pkg::*;
#(
    parameter int unsigned DATA_W  = SERDES_DATA_W,
    parameter int unsigned MOD_W   = $clog2(DATA_W),
    parameter int unsigned MIN_LEN = SERDES_MIN_LEN
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              ser_data_i,
    input  logic              ser_data_val_i,
    output logic [DATA_W-1:0] deser_data_o,
    output logic [MOD_W-1:0]  deser_data_mod_o,
    output logic              deser_data_val_o,
`ifdef DESERIALIZER_RUNT_CNT_EN
    output logic [7:0]        runt_cnt_o,
`endif
    output logic              busy_o
);

    localparam logic [MOD_W:0]    CNT_ONE   = (MOD_W+1)'(1);
    localparam logic [MOD_W:0]    CNT_FULL  = (MOD_W+1)'(DATA_W);
    localparam logic [MOD_W:0]    CNT_MIN   = (MOD_W+1)'(MIN_LEN);
    localparam logic [DATA_W-1:0] MSB_ONE   = {1'b1, {(DATA_W-1){1'b0}}};

    serdes_state_e     state, state_next;
    logic [MOD_W:0]    cnt, cnt_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic [MOD_W-1:0]  mod_reg, mod_next;
    logic              val_reg, val_next;
    logic [DATA_W-1:0] shift_in;
`ifdef DESERIALIZER_RUNT_CNT_EN
    logic [7:0]        runt_cnt, runt_next;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        shift_next = shift_reg;
        data_next  = data_reg;
        mod_next   = mod_reg;
        val_next   = 1'b0;
`ifdef DESERIALIZER_RUNT_CNT_EN
        runt_next  = runt_cnt;
`endif
        // Register with the incoming bit placed at position DATA_W-1-cnt.
        shift_in = ser_data_i ? (shift_reg | (MSB_ONE >> cnt)) : shift_reg;

        case (state)
            IDLE: begin
                if (ser_data_val_i) begin
                    state_next = COLLECT;
                    cnt_next   = CNT_ONE;
                    shift_next = shift_in;
                end
            end
            COLLECT: begin
                if (ser_data_val_i) begin
                    if (cnt + CNT_ONE == CNT_FULL) begin
                        // Word complete: emit and restart so a following bit
                        // begins a fresh word without a bubble.
                        data_next  = shift_in;
                        mod_next   = MOD_W'(MOD_FULL);
                        val_next   = 1'b1;
                        cnt_next   = '0;
                        shift_next = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next   = cnt + CNT_ONE;
                        shift_next = shift_in;
                    end
                end else begin
                    if (cnt >= CNT_MIN) begin
                        // Lower bits are already 0 since the register starts cleared.
                        data_next = shift_reg;
                        mod_next  = cnt[MOD_W-1:0];
                        val_next  = 1'b1;
                    end
`ifdef DESERIALIZER_RUNT_CNT_EN
                    else if (runt_cnt != 8'hFF) begin
                        runt_next = runt_cnt + 8'd1;
                    end
`endif
                    cnt_next   = '0;
                    shift_next = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                shift_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            mod_reg   <= '0;
            val_reg   <= 1'b0;
`ifdef DESERIALIZER_RUNT_CNT_EN
            runt_cnt  <= '0;
`endif
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            mod_reg   <= mod_next;
            val_reg   <= val_next;
`ifdef DESERIALIZER_RUNT_CNT_EN
            runt_cnt  <= runt_next;
`endif
        end
    end

    assign deser_data_o     = data_reg;
    assign deser_data_mod_o = mod_reg;
    assign deser_data_val_o = val_reg;
    assign busy_o           = (state == COLLECT);
`ifdef DESERIALIZER_RUNT_CNT_EN
    assign runt_cnt_o       = runt_cnt;
`endif

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer: the driver updates a bit-queue model of
// the burst rules and pushes expected words; a negedge monitor pops and
// compares whenever deser_data_val_o is high, and checks hold/busy otherwise.
module tb_deserializer;

    localparam int DATA_W  = 16;
    localparam int MOD_W   = 4;
    localparam int MIN_LEN = 3;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [MOD_W-1:0]  mod;
        int                cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              srst = 1'b0;
    logic              ser_data = 1'b0;
    logic              ser_data_val = 1'b0;
    logic [DATA_W-1:0] deser_data;
    logic [MOD_W-1:0]  deser_data_mod;
    logic              deser_data_val;
    logic              busy;
`ifdef DESERIALIZER_RUNT_CNT_EN
    logic [7:0]        runt_cnt;
`endif

    deserializer dut (
        .clk_i            (clk),
        .srst_i           (srst),
        .ser_data_i       (ser_data),
        .ser_data_val_i   (ser_data_val),
        .deser_data_o     (deser_data),
        .deser_data_mod_o (deser_data_mod),
        .deser_data_val_o (deser_data_val),
`ifdef DESERIALIZER_RUNT_CNT_EN
        .runt_cnt_o       (runt_cnt),
`endif
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic cur[$];          // bits of the burst currently being collected
    int   runt_model = 0;
    int   exp_runt = 0;
    logic exp_busy = 1'b0;
    logic exp_zero = 1'b0;
    logic started = 1'b0;
    logic [DATA_W-1:0] last_data = '0;
    logic [MOD_W-1:0]  last_mod = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    // Left-justified word from the collected bits; mod is the bit count (0 if full).
    task automatic emit(input int when);
        exp_t e;
        e.data = '0;
        foreach (cur[i]) e.data[DATA_W-1-i] = cur[i];
        e.mod = (cur.size() == DATA_W) ? '0 : MOD_W'(cur.size());
        e.cyc = when;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic v, input logic b, input logic r);
        int   c;
        logic busy_next;
        c            = cyc;
        srst         = r;
        ser_data_val = v;
        ser_data     = v ? b : 1'($urandom_range(0, 1));
        if (r) begin
            cur.delete();
            runt_model = 0;
        end else if (v) begin
            cur.push_back(b);
            if (cur.size() == DATA_W) begin
                emit(c + 1);
                cur.delete();
            end
        end else if (cur.size() > 0) begin
            if (cur.size() >= MIN_LEN) emit(c + 1);
            else if (runt_model < 255) runt_model++;
            cur.delete();
        end
        busy_next = (cur.size() > 0);
        @(posedge clk);
        #1;
        exp_busy = busy_next;
        exp_zero = r;
        exp_runt = runt_model;
    endtask

    task automatic send(input logic [DATA_W-1:0] w, input int n);
        for (int i = 0; i < n; i++) step(1'b1, w[DATA_W-1-i], 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (started) begin
            if (exp_zero) begin
                chk("reset_data", 32'(deser_data), 32'h0);
                chk("reset_mod", 32'(deser_data_mod), 32'h0);
                chk("reset_val", 32'(deser_data_val), 32'h0);
                last_data = '0;
                last_mod  = '0;
            end else if (deser_data_val) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 32'(deser_data_val), 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pulse_data", 32'(deser_data), 32'(e.data));
                    chk("pulse_mod", 32'(deser_data_mod), 32'(e.mod));
                    chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                    last_data = e.data;
                    last_mod  = e.mod;
                end
            end else begin
                chk("hold_data", 32'(deser_data), 32'(last_data));
                chk("hold_mod", 32'(deser_data_mod), 32'(last_mod));
            end
            chk("busy", 32'(busy), 32'(exp_busy));
`ifdef DESERIALIZER_RUNT_CNT_EN
            chk("runt_cnt", 32'(runt_cnt), 32'(exp_runt));
`endif
        end
    end

    initial begin
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 1'b1);
        started = 1'b1;
        idle(2);

        send(16'hA5C3, 16);               // full word
        idle(3);
        send(16'hB000, 5);                // partial 1,0,1,1,0 -> B000 mod 5
        idle(2);
        send(16'h1234, 16);               // back-to-back pair
        send(16'hFFFF, 16);
        idle(2);
        send(16'hC000, 2);                // runt
        idle(2);
        send(16'h5A5A, 8);                // aborted by reset
        step(1'b0, 1'b0, 1'b1);
        send(16'h00FF, 16);
        idle(2);
        send(16'hBEEF, 7);                // as a serializer would send mod 7
        idle(2);
        send(16'hE000, 3);                // shortest legal burst
        idle(1);
        send(16'h8000, 1);                // single-bit runt
        idle(1);
        send(16'h0000, 15);               // longest partial
        idle(2);

        for (int k = 0; k < 300; k++) begin
            int n;
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 40);
            for (int i = 0; i < n; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 24) == 0) step(1'b0, 1'b0, 1'b1);
            idle($urandom_range(0, 3));
        end
        idle(4);
        started = 1'b0;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receiving end of the serial link driven by the lab2 serializer: 1-bit MSB-first bursts qualified by a valid strobe.
- Reassembles each burst into a parallel word plus a bit-count code, using the same data_mod encoding as the transmitter.
- Emits a single-cycle valid pulse per word.
- Sits between the serial line (or a serializer output in loopback) and downstream parallel logic.

Parameters:
- DATA_W, 16, parallel word width; must be ≥ 4.
- MOD_W, $clog2(DATA_W), width of the bit-count code.
- MIN_LEN, 3, shortest legal burst in bits; shorter bursts are runts.

Ports:
- clk_i  input  1  clock; all logic on posedge.
- srst_i  input  1  synchronous reset, active-high.
- ser_data_i  input  1  serial data bit, sampled when ser_data_val_i=1.
- ser_data_val_i  input  1  bit-valid strobe; contiguous high cycles form one burst.
- deser_data_o  output  DATA_W  assembled word, MSB = first received bit.
- deser_data_mod_o  output  MOD_W  valid-bit count; 0 means a full DATA_W-bit word.
- deser_data_val_o  output  1  one-cycle pulse qualifying deser_data_o and deser_data_mod_o.
- busy_o  output  1  high while a partially collected word is held.

Behaviour:
- Reset (srst_i=1 at a posedge):
  - All outputs 0 from the next cycle.
  - Bit counter cleared; shift register cleared; state IDLE.
  - Any partially collected word is discarded.
  - srst_i has priority over every other event.
- States:
  - IDLE: cnt=0. Enter COLLECT on a sampled valid bit.
  - COLLECT: 0 < cnt < DATA_W.
- Per-cycle sampling, when ser_data_val_i=1:
  - The bit is shifted into shift register position DATA_W-1-cnt.
  - cnt increments.
- Full word (cnt reaches DATA_W):
  - In the cycle after the last bit was sampled: deser_data_val_o=1, deser_data_o = all DATA_W bits, deser_data_mod_o=0.
  - cnt returns to 0.
  - If ser_data_val_i stays high, the next bit starts a new word in that same cycle. There is no bubble and no lost bit.
- Burst end (ser_data_val_i=0 while in COLLECT with cnt=N):
  - If N ≥ MIN_LEN: in the next cycle deser_data_val_o=1. deser_data_o[DATA_W-1:DATA_W-N] holds the received bits and the lower DATA_W-N bits are 0. deser_data_mod_o=N.
  - If N < MIN_LEN: the word is a runt, is dropped, and no pulse is produced.
  - Either way, return to IDLE.
- Latency: exactly 1 cycle from the terminating event to deser_data_val_o.
  - Terminating event = the last full-word bit, or the first low-valid cycle after a burst.
- Output hold between pulses:
  - deser_data_o and deser_data_mod_o keep their last emitted values.
  - deser_data_val_o=0.
- busy_o:
  - 1 whenever cnt > 0 after the current edge.
  - 0 in IDLE, including the cycle that emits a full word, unless a new bit was sampled in that cycle.
- ser_data_i is ignored when ser_data_val_i=0.
- Idle low-valid cycles in IDLE have no effect.
- There is no backpressure; downstream must accept every pulse.

Optional Feature:
- Macro: DESERIALIZER_RUNT_CNT_EN.
- Defined:
  - Adds output runt_cnt_o (8 bits).
  - Increments by 1 on each dropped runt burst (N=1 or 2 with default MIN_LEN) and saturates at 255.
  - Cleared by srst_i.
- Undefined:
  - The port and the counter are absent.
  - Runts are dropped silently.
  - All other behaviour is identical.

Decomposition:
- Shared package serdes_pkg, also used by the serializer:
  - DATA_W, MOD_W and MIN_LEN defaults.
  - A state enum {IDLE, COLLECT}.
  - A localparam for the full-word mod code (0).
- No sub-module is needed; the shift register and counter stay inline in the single module.

Test Plan:
- Full word, 16 contiguous valid bits of 0xA5C3 MSB-first → one cycle after the 16th bit: deser_data_val_o=1, data=0xA5C3, mod=0; busy_o=0 afterwards.
- Partial burst, 5 bits 1,0,1,1,0 then valid low → next cycle: data=0xB000, mod=5, pulse 1 cycle.
- Back-to-back, 32 contiguous valid bits 0x1234 then 0xFFFF → two pulses exactly 16 cycles apart with correct words; no bit lost at the boundary.
- Runt, 2 valid bits then valid low → no pulse; with DESERIALIZER_RUNT_CNT_EN, runt_cnt_o=1.
- Reset mid-burst, 8 bits then srst_i=1 for 1 cycle, then 16 bits of 0x00FF → no pulse for the aborted bits; next pulse data=0x00FF, mod=0.
- Loopback: serializer drives the deserializer with data 0xBEEF, mod 7 → deser_data_o=0xBE00, mod=7.
